quad_encoder_gen: RTL and testbench

Quadrature encoder signal generator: the transmit-side counterpart of the ESC's encoder decoder. It turns a speed/direction/step command into `encoder_a`/`encoder_b` quadrature waveforms plus a once-per-revolution `index`. It serves as a motor-shaft model for closed-loop simulation and as an on-chip stimulus source for bring-up. Its output sequence is exactly the one the ESC decoder classifies as forward or reverse rotation.

---
 rtl/quad_encoder_gen.sv | 185 ++++++++++++++++++
 tb/tb_quad_encoder_gen.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_encoder_gen.sv
`default_nettype none
// ============================================================================
// Module      : quad_encoder_gen
// Description : Quadrature encoder signal generator. Converts a speed /
//               direction / step command into A/B quadrature waveforms, a
//               signed edge position and a once-per-revolution index.
// Revision    : 1.0 - initial release
// ============================================================================
module quad_encoder_gen #(
    parameter int DATA_WIDTH     = 16,
    parameter int COUNTS_PER_REV = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_mode,
    input  logic                  cmd_dir,
    input  logic [DATA_WIDTH-1:0] cmd_period,
    input  logic [DATA_WIDTH-1:0] cmd_steps,
    input  logic                  stop,
    output logic                  encoder_a,
    output logic                  encoder_b,
    output logic                  index,
    output logic [DATA_WIDTH-1:0] position,
    output logic                  busy,
    output logic                  done
);

    localparam int REV_W = (COUNTS_PER_REV > 2) ? $clog2(COUNTS_PER_REV) : 1;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_MOVE = 2'd2;

    localparam logic [DATA_WIDTH-1:0] c_ZERO    = '0;
    localparam logic [DATA_WIDTH-1:0] c_ONE     = DATA_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] c_TWO     = DATA_WIDTH'(2);
    localparam logic [REV_W-1:0]      c_REV_MAX = REV_W'(COUNTS_PER_REV - 1);
    localparam logic [REV_W-1:0]      c_REV_ONE = REV_W'(1);

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic                  r_dir;
    logic [DATA_WIDTH-1:0] r_period;
    logic [DATA_WIDTH-1:0] r_timer;
    logic [DATA_WIDTH-1:0] r_remaining;
    logic [DATA_WIDTH-1:0] r_position;
    logic [REV_W-1:0]      r_rev;
    logic                  r_a;
    logic                  r_b;
    logic                  r_index;
    logic                  r_done;

    logic                  w_active;
    logic                  w_accept;
    logic                  w_expire;
    logic                  w_edge;
    logic                  w_move_last;
    logic                  w_steps_zero;
    logic [DATA_WIDTH-1:0] w_cmd_period;
    logic                  w_a_next;
    logic                  w_b_next;
    logic [REV_W-1:0]      w_rev_next;
    logic [DATA_WIDTH-1:0] w_pos_next;

    // Command handshake, edge timing and qualified edge strobe
    always_comb begin
        w_active     = (r_state == c_ST_RUN) || (r_state == c_ST_MOVE);
        w_accept     = cmd_valid && cmd_ready;
        w_expire     = w_active && (r_timer == (r_period - c_ONE));
        // stop and a freshly accepted command both suppress a due edge
        w_edge       = w_expire && !stop && !w_accept;
        w_move_last  = (r_state == c_ST_MOVE) && (r_remaining == c_ONE);
        w_steps_zero = (cmd_steps == c_ZERO);
        w_cmd_period = (cmd_period < c_TWO) ? c_TWO : cmd_period;
    end

    // Next quadrature phase, revolution count and position for one edge
    always_comb begin
        // Forward rotates {a,b} 00->01->11->10, reverse walks it backwards
        if (r_dir) begin
            w_a_next   = r_b;
            w_b_next   = ~r_a;
            w_rev_next = (r_rev == c_REV_MAX) ? '0 : r_rev + c_REV_ONE;
            w_pos_next = r_position + c_ONE;
        end else begin
            w_a_next   = ~r_b;
            w_b_next   = r_a;
            w_rev_next = (r_rev == '0) ? c_REV_MAX : r_rev - c_REV_ONE;
            w_pos_next = r_position - c_ONE;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE, c_ST_RUN: begin
                if (stop) begin
                    w_next_state = c_ST_IDLE;
                end else if (w_accept) begin
                    if (!cmd_mode) begin
                        w_next_state = c_ST_RUN;
                    end else if (w_steps_zero) begin
                        w_next_state = c_ST_IDLE;
                    end else begin
                        w_next_state = c_ST_MOVE;
                    end
                end
            end
            c_ST_MOVE: begin
                if (stop || (w_edge && w_move_last)) begin
                    w_next_state = c_ST_IDLE;
                end
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    // State-derived outputs
    always_comb begin
        cmd_ready = ((r_state == c_ST_IDLE) || (r_state == c_ST_RUN)) && !stop;
        busy      = (r_state != c_ST_IDLE);
    end

    // Command latch, edge timer and quadrature/position datapath
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dir       <= 1'b0;
            r_period    <= c_TWO;
            r_timer     <= c_ZERO;
            r_remaining <= c_ZERO;
            r_position  <= c_ZERO;
            r_rev       <= '0;
            r_a         <= 1'b0;
            r_b         <= 1'b0;
            r_index     <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= (w_accept && cmd_mode && w_steps_zero) || (w_edge && w_move_last);

            if (w_accept) begin
                r_dir    <= cmd_dir;
                r_period <= w_cmd_period;
                r_timer  <= c_ZERO;
                if (cmd_mode) begin
                    r_remaining <= cmd_steps;
                end
            end else if (!w_active || stop || w_expire) begin
                r_timer <= c_ZERO;
            end else begin
                r_timer <= r_timer + c_ONE;
            end

            if (w_edge) begin
                r_a        <= w_a_next;
                r_b        <= w_b_next;
                r_rev      <= w_rev_next;
                r_index    <= (w_rev_next == '0);
                r_position <= w_pos_next;
                if (r_state == c_ST_MOVE) begin
                    r_remaining <= r_remaining - c_ONE;
                end
            end
        end
    end

    assign encoder_a = r_a;
    assign encoder_b = r_b;
    assign index     = r_index;
    assign position  = r_position;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_quad_encoder_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_quad_encoder_gen
// Description : Directed bench for quad_encoder_gen. Every commanded edge is
//               predicted into a queue; a monitor pops and compares each
//               observed A/B change (cycle, phase, position, index, done).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_quad_encoder_gen;

    localparam int DW  = 16;
    localparam int CPR = 24;

    logic          clk        = 1'b0;
    logic          reset      = 1'b0;
    logic          cmd_valid  = 1'b0;
    logic          cmd_mode   = 1'b0;
    logic          cmd_dir    = 1'b0;
    logic          stop       = 1'b0;
    logic [DW-1:0] cmd_period = '0;
    logic [DW-1:0] cmd_steps  = '0;
    logic          cmd_ready;
    logic          encoder_a;
    logic          encoder_b;
    logic          index;
    logic          busy;
    logic          done;
    logic [DW-1:0] position;

    typedef struct {
        int            cyc;
        logic [1:0]    ab;
        logic [DW-1:0] pos;
        logic          idx;
        logic          dn;
    } exp_t;

    exp_t          q[$];
    exp_t          e;
    int            n_checks = 0;
    int            n_errors = 0;
    int            n_done   = 0;
    int            cyc      = 0;
    int            acc;
    logic [1:0]    prev_ab  = 2'b00;
    logic [1:0]    m_ab     = 2'b00;
    logic [DW-1:0] m_pos    = '0;
    int            m_rev    = 0;
    logic [1:0]    phase_tbl [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    quad_encoder_gen #(.DATA_WIDTH(DW), .COUNTS_PER_REV(CPR)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_mode   (cmd_mode),
        .cmd_dir    (cmd_dir),
        .cmd_period (cmd_period),
        .cmd_steps  (cmd_steps),
        .stop       (stop),
        .encoder_a  (encoder_a),
        .encoder_b  (encoder_b),
        .index      (index),
        .position   (position),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: advance one quadrature edge in direction d
    task automatic m_step(input logic d);
        int p = 0;
        for (int i = 0; i < 4; i++) if (phase_tbl[i] == m_ab) p = i;
        p    = d ? (p + 1) % 4 : (p + 3) % 4;
        m_ab = phase_tbl[p];
        if (d) begin
            m_pos = m_pos + 1'b1;
            m_rev = (m_rev + 1) % CPR;
        end else begin
            m_pos = m_pos - 1'b1;
            m_rev = (m_rev + CPR - 1) % CPR;
        end
    endtask

    task automatic push_edges(input logic d, input int per, input int n, input int acc_cyc, input logic last_done);
        exp_t x;
        for (int k = 1; k <= n; k++) begin
            m_step(d);
            x.cyc = acc_cyc + per * k;
            x.ab  = m_ab;
            x.pos = m_pos;
            x.idx = (m_rev == 0);
            x.dn  = last_done && (k == n);
            q.push_back(x);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        m_ab  = 2'b00;
        m_pos = '0;
        m_rev = 0;
        q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic send_cmd(input logic mode, input logic d, input int per, input int steps, output int acc_cyc);
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_mode   = mode;
        cmd_dir    = d;
        cmd_period = DW'(per);
        cmd_steps  = DW'(steps);
        acc_cyc    = cyc + 1;
        check("cmd_ready_before_accept", cmd_ready, 1);
        @(negedge clk);
        cmd_valid  = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int i = 0;
        while (q.size() != 0 && i < budget) begin
            @(negedge clk);
            #2;
            i++;
        end
        check("drain_timeout", q.size(), 0);
    endtask

    // Monitor: every A/B change must match the next predicted edge
    always @(negedge clk) begin
        if (!reset) begin
            prev_ab = 2'b00;
        end else begin
            if (done) n_done++;
            if ({encoder_a, encoder_b} != prev_ab) begin
                if (q.size() == 0) begin
                    check("unexpected_edge", {encoder_a, encoder_b}, prev_ab);
                end else begin
                    e = q.pop_front();
                    check("edge_cycle", cyc, e.cyc);
                    check("edge_ab", {encoder_a, encoder_b}, e.ab);
                    check("edge_position", position, e.pos);
                    check("edge_index", index, e.idx);
                    check("edge_done", done, e.dn);
                end
                prev_ab = {encoder_a, encoder_b};
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_ab", {encoder_a, encoder_b}, 2'b00);
        check("rst_index", index, 0);
        check("rst_position", position, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b1;
        #1;
        check("rst_cmd_ready", cmd_ready, 1);

        // Continuous forward run, period 4, then stop
        send_cmd(1'b0, 1'b1, 4, 0, acc);
        check("run_busy_rise", busy, 1);
        push_edges(1'b1, 4, 4, acc, 1'b0);
        wait_drain(40);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("run_stop_busy", busy, 0);
        check("run_stop_position", position, 4);
        repeat (6) @(negedge clk);
        check("run_hold_position", position, 4);

        // Reverse move of 5 steps, period 3
        do_reset();
        n_done = 0;
        send_cmd(1'b1, 1'b0, 3, 5, acc);
        push_edges(1'b0, 3, 5, acc, 1'b1);
        wait_drain(40);
        check("move_busy_fall", busy, 0);
        check("move_done", done, 1);
        check("move_position", position, 16'hFFFB);
        check("move_ready_after", cmd_ready, 1);
        @(negedge clk);
        check("move_done_width", done, 0);
        check("move_done_count", n_done, 1);

        // Zero-step move: done pulse only
        n_done = 0;
        send_cmd(1'b1, 1'b1, 7, 0, acc);
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        @(negedge clk);
        check("zero_done_clear", done, 0);
        check("zero_ab_hold", {encoder_a, encoder_b}, 2'b10);
        check("zero_done_count", n_done, 1);

        // Period 0 and 1 are clamped to 2
        send_cmd(1'b0, 1'b1, 0, 0, acc);
        push_edges(1'b1, 2, 3, acc, 1'b0);
        wait_drain(20);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("p0_position", position, 16'hFFFE);
        send_cmd(1'b1, 1'b1, 1, 2, acc);
        push_edges(1'b1, 2, 2, acc, 1'b1);
        wait_drain(20);
        check("p1_position", position, 0);

        // Index over one full revolution, then reverse 1 / forward 1
        do_reset();
        send_cmd(1'b0, 1'b1, 2, 0, acc);
        push_edges(1'b1, 2, CPR, acc, 1'b0);
        wait_drain(80);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("rev_index_high", index, 1);
        send_cmd(1'b1, 1'b0, 2, 1, acc);
        push_edges(1'b0, 2, 1, acc, 1'b1);
        wait_drain(20);
        check("rev_back_index", index, 0);
        send_cmd(1'b1, 1'b1, 2, 1, acc);
        push_edges(1'b1, 2, 1, acc, 1'b1);
        wait_drain(20);
        check("rev_fwd_index", index, 1);

        // Stop on the timer-expiry cycle emits no edge
        do_reset();
        send_cmd(1'b0, 1'b1, 10, 0, acc);
        while (cyc != acc + 9) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_exp_busy", busy, 0);
        check("stop_exp_ab", {encoder_a, encoder_b}, 2'b00);
        check("stop_exp_position", position, 0);

        // Stop together with a command: stop wins
        n_done = 0;
        send_cmd(1'b0, 1'b1, 10, 0, acc);
        @(negedge clk);
        stop      = 1'b1;
        cmd_valid = 1'b1;
        cmd_mode  = 1'b1;
        cmd_steps = 16'd5;
        #1;
        check("stop_cmd_ready", cmd_ready, 0);
        @(negedge clk);
        stop      = 1'b0;
        cmd_valid = 1'b0;
        check("stop_cmd_busy", busy, 0);
        repeat (12) @(negedge clk);
        check("stop_cmd_idle", busy, 0);
        check("stop_cmd_position", position, 0);
        check("stop_cmd_no_done", n_done, 0);

        // Reset mid-move, then a fresh move
        do_reset();
        n_done = 0;
        send_cmd(1'b1, 1'b1, 3, 5, acc);
        push_edges(1'b1, 3, 2, acc, 1'b0);
        wait_drain(20);
        reset = 1'b0;
        #1;
        check("mid_rst_ab", {encoder_a, encoder_b}, 2'b00);
        check("mid_rst_index", index, 0);
        check("mid_rst_position", position, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        m_ab  = 2'b00;
        m_pos = '0;
        m_rev = 0;
        q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_ready", cmd_ready, 1);
        check("mid_rst_no_done", n_done, 0);
        send_cmd(1'b1, 1'b1, 3, 2, acc);
        push_edges(1'b1, 3, 2, acc, 1'b1);
        wait_drain(20);
        check("after_rst_position", position, 2);
        check("after_rst_busy", busy, 0);
        check("after_rst_done_count", n_done, 1);

        repeat (3) @(negedge clk);
        check("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
